spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave.sv | 181 ++++++++++++++++++
 tb/tb_spi_slave.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// spi_slave: SPI slave front end for a 10-bit command/address/data RAM
// protocol. The master sends a command bit, then a 10-bit word, MSB first.
// Bits 9:8 of the word are the opcode and 7:0 the payload. A read-data
// frame returns the RAM byte on MISO, MSB first.
// Optional feature: define SPI_SLAVE_FRAME_ERR_EN to add the frame_err
// output. It pulses when SS_n rises before a word or transmit completes.
module spi_slave (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       SS_n,
  input  logic       MOSI,
  output logic       MISO,
  output logic [9:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid
`ifdef SPI_SLAVE_FRAME_ERR_EN
  ,
  output logic       frame_err
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  state_t      state_q, state_d;
  // hold_q: the frame is finished, or reset hit mid-frame. Ignore the bus
  // until SS_n goes high.
  logic        hold_q, hold_d;
  logic        word_done_q, word_done_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [8:0]  shift_q, shift_d;
  logic [9:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rd_addr_flag_q, rd_addr_flag_d;
  logic        tx_active_q, tx_active_d;
  logic [3:0]  tx_cnt_q, tx_cnt_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        miso_q, miso_d;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic        frame_err_q, frame_err_d;
`endif

  logic receiving;
  logic tx_last;

  assign receiving = !SS_n && !hold_q && !word_done_q &&
                     (state_q == WRITE || state_q == READ_ADD || state_q == READ_DATA);
  // The eighth MISO bit is on the wire. The next edge completes the transmit.
  assign tx_last   = tx_active_q && (tx_cnt_q == 4'd8);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode. SS_n high always returns to IDLE.
  always_comb begin
    state_d = state_q;
    if (SS_n) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (!hold_q) state_d = CHK_CMD;
        CHK_CMD: state_d = MOSI ? (rd_addr_flag_q ? READ_DATA : READ_ADD) : WRITE;
        default: state_d = state_q;
      endcase
    end
  end

  // Datapath next values: deserializer, read-address flag, MISO serializer.
  always_comb begin
    hold_d         = hold_q;
    word_done_d    = word_done_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rd_addr_flag_d = rd_addr_flag_q;
    tx_active_d    = tx_active_q;
    tx_cnt_d       = tx_cnt_q;
    tx_shift_d     = tx_shift_q;
    miso_d         = 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    frame_err_d    = 1'b0;
`endif
    if (SS_n) begin
      // End of frame. A partial word is dropped without touching rd_addr_flag.
      hold_d      = 1'b0;
      word_done_d = 1'b0;
      bit_cnt_d   = 4'd0;
      tx_active_d = 1'b0;
      tx_cnt_d    = 4'd0;
      tx_shift_d  = 8'd0;
      if (tx_last) rd_addr_flag_d = 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err_d = (state_q != IDLE) && !hold_q && !tx_last;
`endif
    end else if (receiving) begin
      shift_d = {shift_q[7:0], MOSI};
      if (bit_cnt_q == 4'd9) begin
        rx_data_d  = {shift_q, MOSI};
        rx_valid_d = 1'b1;
        bit_cnt_d  = 4'd0;
        if (state_q == READ_DATA) word_done_d = 1'b1;
        else                      hold_d      = 1'b1;
        if (state_q == READ_ADD)  rd_addr_flag_d = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (state_q == READ_DATA && word_done_q && !hold_q) begin
      if (!tx_active_q) begin
        if (tx_valid) begin
          miso_d      = tx_data[7];
          tx_shift_d  = {tx_data[6:0], 1'b0};
          tx_cnt_d    = 4'd1;
          tx_active_d = 1'b1;
        end
      end else if (tx_last) begin
        tx_active_d    = 1'b0;
        tx_cnt_d       = 4'd0;
        hold_d         = 1'b1;
        rd_addr_flag_d = 1'b0;
      end else begin
        miso_d     = tx_shift_q[7];
        tx_shift_d = {tx_shift_q[6:0], 1'b0};
        tx_cnt_d   = tx_cnt_q + 4'd1;
      end
    end
  end

  // Datapath registers. hold_q resets high, so a frame cut by reset is
  // not resumed until SS_n is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q         <= 1'b1;
      word_done_q    <= 1'b0;
      bit_cnt_q      <= 4'd0;
      shift_q        <= 9'd0;
      rx_data_q      <= 10'd0;
      rx_valid_q     <= 1'b0;
      rd_addr_flag_q <= 1'b0;
      tx_active_q    <= 1'b0;
      tx_cnt_q       <= 4'd0;
      tx_shift_q     <= 8'd0;
      miso_q         <= 1'b0;
    end else begin
      hold_q         <= hold_d;
      word_done_q    <= word_done_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rd_addr_flag_q <= rd_addr_flag_d;
      tx_active_q    <= tx_active_d;
      tx_cnt_q       <= tx_cnt_d;
      tx_shift_q     <= tx_shift_d;
      miso_q         <= miso_d;
    end
  end

`ifdef SPI_SLAVE_FRAME_ERR_EN
  // Frame error strobe register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_err_q <= 1'b0;
    else        frame_err_q <= frame_err_d;
  end
  assign frame_err = frame_err_q;
`endif

  assign MISO     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: randomized frame-level bench for spi_slave. The reference
// model tracks the read-address flag and the last delivered word per frame.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic       frame_err;
`endif

  spi_slave dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    .frame_err(frame_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulses;
  int miso_bad;

  // Reference model state.
  bit         model_rd_flag = 1'b0;
  logic [9:0] model_rx      = 10'd0;

  // Advance one edge, then sample outputs just after it.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rx_valid === 1'b1) pulses++;
    if (MISO !== 1'b0) miso_bad++;
  endtask

  // One frame. abort_at < 0 runs a full frame; otherwise SS_n rises after
  // abort_at data bits.
  task automatic run_frame(input bit cmd, input logic [9:0] word, input logic [7:0] txb,
                           input int txdelay, input int abort_at);
    bit         rd_data;
    logic [7:0] got;
    rd_data  = cmd && model_rd_flag;
    pulses   = 0;
    miso_bad = 0;
    got      = 8'd0;
    SS_n = 1'b0; MOSI = 1'($urandom); tx_valid = 1'b0;
    tick();
    MOSI = cmd;
    tick();
    for (int n = 0; n < 10; n++) begin
      if (n == abort_at) break;
      MOSI = word[9-n];
      if (!rd_data) tx_valid = 1'($urandom);
      tick();
    end
    if (abort_at >= 0) begin
      SS_n = 1'b1; tx_valid = 1'b0;
      tick();
      checks++;
      if (pulses !== 0 || miso_bad !== 0) begin
        errors++;
        $display("FAIL abort_quiet: pulses=%0d miso_bad=%0d required 0/0", pulses, miso_bad);
      end
`ifdef SPI_SLAVE_FRAME_ERR_EN
      checks++;
      if (frame_err !== 1'b1) begin
        errors++;
        $display("FAIL frame_err_pulse: got %b required 1", frame_err);
      end
`endif
      tick();
`ifdef SPI_SLAVE_FRAME_ERR_EN
      checks++;
      if (frame_err !== 1'b0) begin
        errors++;
        $display("FAIL frame_err_clear: got %b required 0", frame_err);
      end
`endif
      checks++;
      if (rx_data !== model_rx) begin
        errors++;
        $display("FAIL abort_hold: rx_data=%h required %h", rx_data, model_rx);
      end
      $display("frame cmd=%0d word=%h aborted after %0d bits", cmd, word, abort_at);
      return;
    end
    // The 10th data bit has just been sampled.
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== word) begin
      errors++;
      $display("FAIL rx_word: rx_valid=%b rx_data=%h required 1/%h", rx_valid, rx_data, word);
    end
    model_rx = word;
    if (rd_data) begin
      tx_valid = 1'b0;
      repeat (txdelay) begin MOSI = 1'($urandom); tick(); end
      tx_valid = 1'b1; tx_data = txb;
      tick();
      got[7] = MISO;
      tx_valid = 1'b0; tx_data = 8'($urandom);
      for (int k = 6; k >= 0; k--) begin
        MOSI = 1'($urandom);
        tick();
        got[k] = MISO;
      end
      miso_bad = 0;
      checks++;
      if (got !== txb) begin
        errors++;
        $display("FAIL miso_byte: got %h required %h", got, txb);
      end
      tx_valid = 1'b1; tx_data = 8'($urandom);
      tick();
      tick();
      tx_valid = 1'b0;
      model_rd_flag = 1'b0;
    end else begin
      if (cmd) model_rd_flag = 1'b1;
      repeat (3) begin MOSI = 1'($urandom); tx_valid = 1'($urandom); tick(); end
    end
    checks++;
    if (pulses !== 1 || miso_bad !== 0) begin
      errors++;
      $display("FAIL frame_strobes: pulses=%0d miso_bad=%0d required 1/0", pulses, miso_bad);
    end
    SS_n = 1'b1; tx_valid = 1'b0;
    tick();
    checks++;
    if (rx_data !== model_rx || rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL rx_hold: rx_data=%h rx_valid=%b required %h/0", rx_data, rx_valid, model_rx);
    end
`ifdef SPI_SLAVE_FRAME_ERR_EN
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL frame_err_idle: got %b required 0", frame_err);
    end
`endif
    $display("frame cmd=%0d word=%h rd_data=%0d tx=%h miso=%h", cmd, word, rd_data, txb, got);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'd0;
    #12;
    checks++;
    if (MISO !== 1'b0 || rx_valid !== 1'b0 || rx_data !== 10'd0) begin
      errors++;
      $display("FAIL reset_state: MISO=%b rx_valid=%b rx_data=%h required 0/0/000",
               MISO, rx_valid, rx_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    model_rd_flag = 1'b0;
    model_rx      = 10'd0;
  endtask

  task automatic test_write();
    run_frame(1'b0, 10'h0A5, 8'h00, 0, -1);
    run_frame(1'b0, 10'h13C, 8'h00, 0, -1);
  endtask

  task automatic test_read_pair();
    if (model_rd_flag) run_frame(1'b1, 10'h3FF, 8'h5A, 0, -1);
    run_frame(1'b1, 10'h207, 8'h00, 0, -1);
    run_frame(1'b1, {2'b11, 8'($urandom)}, 8'hC3, 1, -1);
    // With the flag cleared, this command-1 frame is a read address again.
    run_frame(1'b1, 10'h2F0, 8'hAA, 0, -1);
  endtask

  task automatic test_abort();
    run_frame(1'b0, 10'h155, 8'h00, 0, 5);
    // An aborted read-data word leaves the flag set; the next read still transmits.
    run_frame(1'b1, 10'h3C3, 8'h3C, 0, 5);
    run_frame(1'b1, 10'h301, 8'h96, 2, -1);
  endtask

  task automatic test_reset_mid_tx();
    if (model_rd_flag == 1'b0) run_frame(1'b1, 10'h2AA, 8'h00, 0, -1);
    SS_n = 1'b0; MOSI = 1'b0; tx_valid = 1'b0;
    tick();
    MOSI = 1'b1;
    tick();
    for (int n = 0; n < 10; n++) begin MOSI = 1'($urandom); tick(); end
    tx_valid = 1'b1; tx_data = 8'hFF;
    tick();
    tx_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (MISO !== 1'b1) begin
      errors++;
      $display("FAIL tx_ongoing: MISO=%b required 1", MISO);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (MISO !== 1'b0 || rx_valid !== 1'b0 || rx_data !== 10'd0) begin
      errors++;
      $display("FAIL async_reset: MISO=%b rx_valid=%b rx_data=%h required 0/0/000",
               MISO, rx_valid, rx_data);
    end
    model_rd_flag = 1'b0;
    model_rx      = 10'd0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulses = 0; miso_bad = 0;
    for (int n = 0; n < 14; n++) begin MOSI = 1'($urandom); tick(); end
    checks++;
    if (pulses !== 0 || miso_bad !== 0) begin
      errors++;
      $display("FAIL post_reset_lockout: pulses=%0d miso_bad=%0d required 0/0", pulses, miso_bad);
    end
    SS_n = 1'b1;
    tick();
    run_frame(1'b0, 10'($urandom), 8'h00, 0, -1);
    run_frame(1'b1, 10'h211, 8'h77, 0, -1);
    run_frame(1'b1, 10'h322, 8'h81, 0, -1);
  endtask

  task automatic test_random();
    for (int f = 0; f < 24; f++) begin
      int ab;
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 9)) : -1;
      run_frame(1'($urandom), 10'($urandom), 8'($urandom), int'($urandom_range(0, 3)), ab);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_pair();
    test_abort();
    test_reset_mid_tx();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
